// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
package mips_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned CLASS_W  = 3;
  localparam int unsigned SEL_W    = 2;

  // Primary opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // Controller states
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC_R = 4'd6,
    ST_EXEC_I = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_TRAP   = 4'd11
  } state_e;

  // Instruction classes produced by the opcode decoder
  typedef enum logic [CLASS_W-1:0] {
    CLS_RTYPE = 3'd0,
    CLS_IMM   = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_BEQ   = 3'd4,
    CLS_BNE   = 3'd5,
    CLS_JUMP  = 3'd6,
    CLS_NONE  = 3'd7
  } op_class_e;

  // ALU B-operand select
  localparam logic [SEL_W-1:0] SRCB_B       = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

  // ALU operation class
  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [SEL_W-1:0] ALUOP_IMM   = 2'b11;

  // Next-PC source
  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control bundle
  typedef struct packed {
    logic             pc_en;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] pc_source;
    logic             instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode -> instruction class / legality decode.
module mc_opcode_class
  import mips_pkg::*;
(
  input  logic [OP_W-1:0] i_opcode,
  output op_class_e       o_class,
  output logic            o_legal
);

  // Map each supported opcode onto its class; everything else is illegal
  always_comb begin
    o_class = CLS_NONE;
    o_legal = 1'b1;
    case (i_opcode)
      OP_RTYPE: o_class = CLS_RTYPE;
      OP_ADDI,
      OP_SLTI,
      OP_ANDI,
      OP_ORI,
      OP_XORI:  o_class = CLS_IMM;
      OP_LW:    o_class = CLS_LOAD;
      OP_SW:    o_class = CLS_STORE;
      OP_BEQ:   o_class = CLS_BEQ;
      OP_BNE:   o_class = CLS_BNE;
      OP_J:     o_class = CLS_JUMP;
      default: begin
        o_class = CLS_NONE;
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: Moore sequencer for the shared datapath.
module mc_control_fsm
  import mips_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] OpCode,
  input  logic            Zero,
  input  logic            MemReady,
  output logic            PCEn,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [SEL_W-1:0] ALUSrcB,
  output logic [SEL_W-1:0] ALUOp,
  output logic [SEL_W-1:0] PCSource,
  output logic            InstrDone,
  output logic            IllegalOp
);

  state_e    r_state;
  logic      r_bne;
  logic      r_rtype;
  logic      r_illegal;
  op_class_e w_class;
  logic      w_legal;
  logic      w_mem_rdy;
  ctrl_t     w_ctrl;

  mc_opcode_class u_opcode_class (
    .i_opcode (OpCode),
    .o_class  (w_class),
    .o_legal  (w_legal)
  );

  // Memory handshake can be strapped off for zero-wait memories
  assign w_mem_rdy = MEM_WAIT_EN ? MemReady : 1'b1;

  // State sequencing plus the flags captured during DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_bne     <= 1'b0;
      r_rtype   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_mem_rdy) r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          r_bne   <= (w_class == CLS_BNE);
          r_rtype <= (w_class == CLS_RTYPE);
          if (!w_legal) begin
            r_state   <= ST_TRAP;
            r_illegal <= 1'b1;
          end else begin
            case (w_class)
              CLS_LOAD,
              CLS_STORE: r_state <= ST_MEMADR;
              CLS_RTYPE: r_state <= ST_EXEC_R;
              CLS_IMM:   r_state <= ST_EXEC_I;
              CLS_BEQ,
              CLS_BNE:   r_state <= ST_BRANCH;
              CLS_JUMP:  r_state <= ST_JUMP;
              default: begin
                r_state   <= ST_TRAP;
                r_illegal <= 1'b1;
              end
            endcase
          end
        end
        ST_MEMADR: begin
          // OpCode is held stable by the IR for the whole instruction
          r_state <= (w_class == CLS_STORE) ? ST_MEMWR : ST_MEMRD;
        end
        ST_MEMRD: begin
          if (w_mem_rdy) r_state <= ST_MEMWB;
        end
        ST_MEMWB:  r_state <= ST_FETCH;
        ST_MEMWR: begin
          if (w_mem_rdy) r_state <= ST_FETCH;
        end
        ST_EXEC_R: r_state <= ST_ALUWB;
        ST_EXEC_I: r_state <= ST_ALUWB;
        ST_ALUWB:  r_state <= ST_FETCH;
        ST_BRANCH: r_state <= ST_FETCH;
        ST_JUMP:   r_state <= ST_FETCH;
        ST_TRAP:   r_state <= ST_TRAP;
        default:   r_state <= ST_FETCH;
      endcase
    end
  end

  // Control outputs decoded from the current state
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      ST_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.iord      = 1'b0;
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.pc_source = PCSRC_ALU;
        w_ctrl.ir_write  = w_mem_rdy;
        w_ctrl.pc_en     = w_mem_rdy;
      end
      ST_DECODE: begin
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = SRCB_IMM_SH2;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
      end
      ST_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        // Write strobe held level for the entire wait
        w_ctrl.mem_write  = 1'b1;
        w_ctrl.iord       = 1'b1;
        w_ctrl.instr_done = w_mem_rdy;
      end
      ST_EXEC_R: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_B;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_EXEC_I: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_IMM;
      end
      ST_ALUWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b0;
        w_ctrl.reg_dst    = r_rtype;
        w_ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        w_ctrl.alu_src_a  = 1'b1;
        w_ctrl.alu_src_b  = SRCB_B;
        w_ctrl.alu_op     = ALUOP_SUB;
        w_ctrl.pc_source  = PCSRC_ALUOUT;
        w_ctrl.instr_done = 1'b1;
        w_ctrl.pc_en      = Zero ^ r_bne;
      end
      ST_JUMP: begin
        w_ctrl.pc_source  = PCSRC_JUMP;
        w_ctrl.pc_en      = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      ST_TRAP: w_ctrl = '0;
      default: w_ctrl = '0;
    endcase
  end

  assign PCEn      = w_ctrl.pc_en;
  assign IorD      = w_ctrl.iord;
  assign MemRead   = w_ctrl.mem_read;
  assign MemWrite  = w_ctrl.mem_write;
  assign IRWrite   = w_ctrl.ir_write;
  assign RegDst    = w_ctrl.reg_dst;
  assign MemtoReg  = w_ctrl.mem_to_reg;
  assign RegWrite  = w_ctrl.reg_write;
  assign ALUSrcA   = w_ctrl.alu_src_a;
  assign ALUSrcB   = w_ctrl.alu_src_b;
  assign ALUOp     = w_ctrl.alu_op;
  assign PCSource  = w_ctrl.pc_source;
  assign InstrDone = w_ctrl.instr_done;
  assign IllegalOp = r_illegal;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle MIPS control unit: a Moore FSM that sequences the shared datapath (single memory, one ALU, IR, A/B/ALUOut registers) across FETCH/DECODE/EXEC/MEM/WB steps.
- Supports the same ISA subset as the single-cycle design: R-type, ADDI, SLTI, ANDI, ORI, XORI, J, BEQ, BNE, LW, SW.
- Stalls on a memory-ready handshake.
- Sits between the instruction register opcode field and the multi-cycle datapath muxes and enables.

Parameters:
- MEM_WAIT_EN, 1, 1 = memory states wait for MemReady; 0 = MemReady is treated as constant 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- OpCode  in  6  IR[31:26]; stable from the DECODE cycle until the next FETCH completes.
- Zero  in  1  ALU zero flag, valid in the BRANCH cycle.
- MemReady  in  1  memory access completes this cycle.
- PCEn  out  1  PC register write enable.
- IorD  out  1  0 = memory address from PC; 1 = from ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load IR.
- RegDst  out  1  1 = write Rd; 0 = write Rt.
- MemtoReg  out  1  1 = write-back data from MDR.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC; 1 = A register.
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded, 11 = opcode-decoded immediate.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- InstrDone  out  1  one-cycle pulse on the last cycle of each instruction.
- IllegalOp  out  1  sticky: an unsupported opcode was decoded.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP, TRAP. Encoding is 4-bit.
- Reset (rst_n = 0, asynchronous): state = FETCH, IllegalOp = 0, branch-type flag = 0.
- All outputs are decoded from state. The values listed per state below are the only non-zero values; every other output is 0. During reset the outputs therefore equal the FETCH values.
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite = PCEn = MemReady.
  - Next state = DECODE if MemReady, else stay in FETCH.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut).
  - Branch-type flag is registered from OpCode: 1 = BNE.
  - Next state: LW/SW -> MEMADR; RTYPE -> EXEC_R; ADDI/SLTI/ANDI/ORI/XORI -> EXEC_I; BEQ/BNE -> BRANCH; J -> JUMP; anything else -> TRAP.
- MEMADR:
  - ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00.
  - Next state = MEMRD for LW, MEMWR for SW.
- MEMRD:
  - MemRead = 1, IorD = 1.
  - Wait for MemReady, then MEMWB.
- MEMWB:
  - RegWrite = 1, MemtoReg = 1, RegDst = 0, InstrDone = 1.
  - Next state = FETCH.
- MEMWR:
  - MemWrite = 1, IorD = 1.
  - InstrDone = MemReady.
  - Wait for MemReady, then FETCH.
  - MemWrite is held continuously while waiting, never pulsed.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next state = ALUWB with RegDst = 1.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 11. Next state = ALUWB with RegDst = 0.
- ALUWB:
  - RegWrite = 1, MemtoReg = 0, InstrDone = 1.
  - RegDst = 1 if the registered opcode class is R-type, else 0.
  - Next state = FETCH.
- BRANCH:
  - ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSource = 01, InstrDone = 1.
  - PCEn = Zero XOR bne_flag.
  - Next state = FETCH.
- JUMP: PCSource = 10, PCEn = 1, InstrDone = 1. Next state = FETCH.
- TRAP:
  - IllegalOp is set on entry and stays set until reset.
  - All strobes and enables are 0.
  - The FSM stays in TRAP (halts) until reset.
- Latency (MemReady = 1 throughout): LW = 5 cycles; SW, R-type and I-type = 4 cycles; BEQ, BNE and J = 3 cycles.
- MemReady outside FETCH, MEMRD and MEMWR is ignored.
- A reset asserted mid-instruction drops all strobes immediately (asynchronous) and restarts at FETCH.
- MemWrite and RegWrite are never 1 in the same cycle. PCEn and RegWrite are never 1 in the same cycle.

Decomposition:
- Shared package mips_pkg:
  - Opcode localparams: OP_RTYPE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_J, OP_BEQ, OP_BNE, OP_LW, OP_SW.
  - State encoding.
  - ALUSrcB, ALUOp and PCSource codes.
- One sub-module, mc_opcode_class: combinational opcode -> {class, legal} decode, reused by DECODE next-state logic and the flag register.

Test Plan:
- LW (OpCode = 100011), MemReady = 1: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegWrite = 1 and MemtoReg = 1 only in cycle 5. InstrDone pulses once.
- SW (101011) with MemReady low for 3 cycles in MEMWR: MemWrite = 1 for 4 consecutive cycles. Return to FETCH after MemReady. RegWrite stays 0.
- Branches:
  - BEQ with Zero = 1: PCEn = 1, PCSource = 01 in cycle 3.
  - BEQ with Zero = 0: PCEn = 0.
  - BNE with Zero = 0: PCEn = 1.
- R-type (000000) then ORI (001101): ALUOp = 10 / RegDst = 1 for R-type, then ALUOp = 11 / RegDst = 0 for ORI. 4 cycles each.
- Illegal opcode 111111: the FSM enters TRAP after DECODE. IllegalOp = 1 and stays set. No strobes. Deasserting rst_n clears IllegalOp and returns the FSM to FETCH.
- rst_n pulled low during MEMWR with MemWrite = 1: MemWrite drops with no clock edge. After release the FSM is in FETCH with MemRead = 1.
